terminal_console: RTL and testbench



---
 rtl/terminal_console.sv | 157 +++++++++++++++
 tb/tb_terminal_console.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/terminal_console.sv
// Character-stream front end for the Terminal text buffer: cursor tracking,
// glyph writes, CR/LF/BS handling, scroll-up and full-screen clear.
module terminal_console #(
    parameter int          COLUMNS       = 80,
    parameter int          ROWS          = 30,
    parameter int          ADDRESS_WIDTH = 12,
    parameter logic [7:0]  BLANK_CHAR    = 8'h20
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     charValid,
    input  logic [7:0]               charData,
    output logic                     charReady,
    input  logic                     clearScreen,
    output logic                     isBusy,
    output logic [6:0]               cursorX,
    output logic [4:0]               cursorY,
    output logic [ADDRESS_WIDTH-1:0] textAddress,
    input  logic [7:0]               textReadData,
    output logic                     shouldWriteText,
    output logic [7:0]               textWriteData
);

    localparam int AW = ADDRESS_WIDTH;
    localparam logic [AW-1:0] COLS_A        = AW'(COLUMNS);
    localparam logic [AW-1:0] LAST_SRC      = AW'((ROWS - 1) * COLUMNS - 1);
    localparam logic [AW-1:0] LAST_ROW_BASE = AW'((ROWS - 1) * COLUMNS);
    localparam logic [AW-1:0] LAST_ADDR     = AW'(ROWS * COLUMNS - 1);
    localparam logic [6:0]    LAST_COL      = 7'(COLUMNS - 1);
    localparam logic [4:0]    LAST_ROW      = 5'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE, PROCESS, SCROLL_READ, SCROLL_HOLD, SCROLL_WRITE, CLEAR_ROW, CLEAR_ALL
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      cursor_x_q, cursor_x_d;
    logic [4:0]      cursor_y_q, cursor_y_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wr_q, wr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      byte_q, byte_d;
    logic            newline;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    assign charReady       = (state_q == IDLE) && !clearScreen && reset;
    assign isBusy          = (state_q != IDLE);
    assign cursorX         = cursor_x_q;
    assign cursorY         = cursor_y_q;
    assign textAddress     = addr_q;
    assign shouldWriteText = wr_q;
    assign textWriteData   = wdata_q;

    always_comb begin
        state_d    = state_q;
        cursor_x_d = cursor_x_q;
        cursor_y_d = cursor_y_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        byte_d     = byte_q;
        wr_d       = 1'b0;
        newline    = 1'b0;
        case (state_q)
            IDLE: begin
                if (clearScreen) begin
                    state_d    = CLEAR_ALL;
                    cursor_x_d = '0;
                    cursor_y_d = '0;
                    addr_d     = '0;
                    wdata_d    = BLANK_CHAR;
                    wr_d       = 1'b1;
                end else if (charValid) begin
                    // Glyph write is set up here so the strobe is visible during PROCESS.
                    state_d = PROCESS;
                    byte_d  = charData;
                    addr_d  = AW'(cursor_y_q) * COLS_A + AW'(cursor_x_q);
                    wdata_d = charData;
                    wr_d    = is_printable(charData);
                end
            end
            PROCESS: begin
                state_d = IDLE;
                if (is_printable(byte_q)) begin
                    if (cursor_x_q < LAST_COL) cursor_x_d = cursor_x_q + 7'd1;
                    else                       newline    = 1'b1;
                end else if (byte_q == 8'h0A) begin
                    newline = 1'b1;
                end else if (byte_q == 8'h0D) begin
                    cursor_x_d = '0;
                end else if ((byte_q == 8'h08) && (cursor_x_q != '0)) begin
                    cursor_x_d = cursor_x_q - 7'd1;
                end
                if (newline) begin
                    cursor_x_d = '0;
                    if (cursor_y_q < LAST_ROW) begin
                        cursor_y_d = cursor_y_q + 5'd1;
                    end else begin
                        state_d = SCROLL_READ;
                        addr_d  = COLS_A;
                    end
                end
            end
            SCROLL_READ: state_d = SCROLL_HOLD;
            SCROLL_HOLD: begin
                // textAddress doubles as the scroll index: source is i+COLUMNS, destination i.
                state_d = SCROLL_WRITE;
                addr_d  = addr_q - COLS_A;
                wdata_d = textReadData;
                wr_d    = 1'b1;
            end
            SCROLL_WRITE: begin
                if (addr_q == LAST_SRC) begin
                    state_d = CLEAR_ROW;
                    addr_d  = LAST_ROW_BASE;
                    wdata_d = BLANK_CHAR;
                    wr_d    = 1'b1;
                end else begin
                    state_d = SCROLL_READ;
                    addr_d  = addr_q + COLS_A + AW'(1);
                end
            end
            CLEAR_ROW, CLEAR_ALL: begin
                // Both clears end on the last screen cell.
                if (addr_q == LAST_ADDR) begin
                    state_d = IDLE;
                end else begin
                    addr_d = addr_q + AW'(1);
                    wr_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            cursor_x_q <= '0;
            cursor_y_q <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cursor_x_q <= cursor_x_d;
            cursor_y_q <= cursor_y_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            byte_q     <= byte_d;
        end
    end

endmodule

// File: tb/tb_terminal_console.sv
// Bench for terminal_console: Terminal memory model plus a character-level
// reference model of cursor and screen contents.
module tb_terminal_console;

    localparam int COLS       = 80;
    localparam int ROWS       = 30;
    localparam int AW         = 12;
    localparam int NCELL      = COLS * ROWS;
    localparam int SCROLL_CYC = 3 * (ROWS - 1) * COLS + COLS;

    logic          clock;
    logic          reset;
    logic          charValid;
    logic [7:0]    charData;
    logic          charReady;
    logic          clearScreen;
    logic          isBusy;
    logic [6:0]    cursorX;
    logic [4:0]    cursorY;
    logic [AW-1:0] textAddress;
    logic [7:0]    textReadData;
    logic          shouldWriteText;
    logic [7:0]    textWriteData;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem     [0:NCELL-1];
    logic [7:0] exp_mem [0:NCELL-1];
    int ex = 0;
    int ey = 0;

    terminal_console #(.COLUMNS(COLS), .ROWS(ROWS), .ADDRESS_WIDTH(AW), .BLANK_CHAR(8'h20)) dut (
        .clock(clock), .reset(reset), .charValid(charValid), .charData(charData),
        .charReady(charReady), .clearScreen(clearScreen), .isBusy(isBusy),
        .cursorX(cursorX), .cursorY(cursorY), .textAddress(textAddress),
        .textReadData(textReadData), .shouldWriteText(shouldWriteText),
        .textWriteData(textWriteData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Terminal text memory: synchronous read of the address seen at the edge, read-before-write.
    always @(posedge clock) begin
        if (shouldWriteText) mem[textAddress] <= textWriteData;
        textReadData <= mem[textAddress];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_newline(output bit scr);
        scr = 1'b0;
        ex  = 0;
        if (ey < ROWS - 1) begin
            ey++;
        end else begin
            scr = 1'b1;
            for (int a = 0; a < (ROWS - 1) * COLS; a++) exp_mem[a] = exp_mem[a + COLS];
            for (int a = (ROWS - 1) * COLS; a < NCELL; a++) exp_mem[a] = 8'h20;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, output bit scr);
        scr = 1'b0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_mem[ey * COLS + ex] = b;
            if (ex < COLS - 1) ex++;
            else model_newline(scr);
        end else if (b == 8'h0A) begin
            model_newline(scr);
        end else if (b == 8'h0D) begin
            ex = 0;
        end else if (b == 8'h08 && ex > 0) begin
            ex--;
        end
    endtask

    task automatic compare_mem(input string tag);
        int bad = 0;
        for (int a = 0; a < NCELL; a++) if (mem[a] !== exp_mem[a]) bad++;
        chk(tag, bad, 0);
    endtask

    // Called at a falling edge with the console idle.
    task automatic send_byte(input logic [7:0] b);
        int  n = 0;
        int  busy = 0;
        bit  pr;
        bit  scr;
        int  ea;
        while (!charReady && n < 10000) begin @(negedge clock); n++; end
        pr = (b >= 8'h20 && b <= 8'h7E);
        ea = ey * COLS + ex;
        charValid = 1'b1;
        charData  = b;
        @(negedge clock);
        charValid = 1'b0;
        chk("write_strobe", shouldWriteText, pr);
        if (pr) begin
            chk("write_addr", textAddress, ea);
            chk("write_data", textWriteData, b);
        end
        model_byte(b, scr);
        while (isBusy && busy < 8000) begin busy++; @(negedge clock); end
        chk("busy_cycles", busy, scr ? 1 + SCROLL_CYC : 1);
        chk("cursor_x", cursorX, ex);
        chk("cursor_y", cursorY, ey);
    endtask

    task automatic do_clear(input bit with_byte);
        int n = 0;
        int writes = 0;
        int bad = 0;
        bit scr;
        clearScreen = 1'b1;
        if (with_byte) begin charValid = 1'b1; charData = 8'h5A; end
        #1 chk("ready_clear_req", charReady, 1'b0);
        @(negedge clock);
        clearScreen = 1'b0;
        while (isBusy && n < 3000) begin
            if (shouldWriteText) begin
                if (textAddress !== AW'(writes) || textWriteData !== 8'h20) bad++;
                writes++;
            end
            n++;
            @(negedge clock);
        end
        chk("clear_writes", writes, NCELL);
        chk("clear_bad", bad, 0);
        chk("clear_cursor_x", cursorX, 0);
        chk("clear_cursor_y", cursorY, 0);
        for (int a = 0; a < NCELL; a++) exp_mem[a] = 8'h20;
        ex = 0;
        ey = 0;
        if (with_byte) begin
            @(negedge clock);
            charValid = 1'b0;
            chk("late_byte_wr", shouldWriteText, 1'b1);
            chk("late_byte_addr", textAddress, 0);
            chk("late_byte_data", textWriteData, 8'h5A);
            model_byte(8'h5A, scr);
            @(negedge clock);
            chk("late_cursor_x", cursorX, ex);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit scr;
        int n;
        int w;
        logic [7:0] b;
        reset = 1'b0; charValid = 1'b0; charData = 8'h00; clearScreen = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_ready", charReady, 1'b0);
        chk("rst_busy", isBusy, 1'b0);
        chk("rst_cx", cursorX, 0);
        chk("rst_cy", cursorY, 0);
        chk("rst_addr", textAddress, 0);
        chk("rst_wr", shouldWriteText, 1'b0);
        chk("rst_wdata", textWriteData, 0);
        reset = 1'b1;

        // 'H','i' with charValid held
        @(negedge clock);
        charValid = 1'b1; charData = 8'h48;
        #1 chk("hi_ready0", charReady, 1'b1);
        @(negedge clock);
        chk("hi_ready1", charReady, 1'b0);
        chk("h_wr", shouldWriteText, 1'b1);
        chk("h_addr", textAddress, 0);
        chk("h_data", textWriteData, 8'h48);
        charData = 8'h69;
        @(negedge clock);
        chk("hi_ready2", charReady, 1'b1);
        chk("hi_idle_wr", shouldWriteText, 1'b0);
        @(negedge clock);
        chk("i_wr", shouldWriteText, 1'b1);
        chk("i_addr", textAddress, 1);
        chk("i_data", textWriteData, 8'h69);
        charValid = 1'b0;
        model_byte(8'h48, scr);
        model_byte(8'h69, scr);
        @(negedge clock);
        chk("hi_cx", cursorX, 2);
        chk("hi_cy", cursorY, 0);

        // Reach (5,3), then CR, LF, BS
        send_byte(8'h0A); send_byte(8'h0A); send_byte(8'h0A);
        for (int k = 0; k < 5; k++) send_byte(8'h41 + 8'(k));
        send_byte(8'h0D); send_byte(8'h0A); send_byte(8'h08);

        // Clear requested together with a byte
        do_clear(1'b1);
        compare_mem("mem_after_clear");

        // Random byte stream
        for (int k = 0; k < 150; k++) begin
            n = $urandom_range(0, 99);
            if (n < 70)      b = 8'($urandom_range(8'h20, 8'h7E));
            else if (n < 75) b = 8'h0A;
            else if (n < 82) b = 8'h0D;
            else if (n < 90) b = 8'h08;
            else if (n < 95) b = 8'($urandom_range(0, 7));
            else             b = 8'($urandom_range(8'h7F, 8'hFF));
            send_byte(b);
        end
        compare_mem("mem_after_random");

        // Fill row 0 exactly
        do_clear(1'b0);
        for (int k = 0; k < COLS; k++) send_byte(8'h21 + 8'(k));
        chk("row0_cx", cursorX, 0);
        chk("row0_cy", cursorY, 1);

        // Preload rows with r+0x30, cursor (10,29), then LF scrolls
        do_clear(1'b0);
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++) send_byte(8'h30 + 8'(r));
        for (int c = 0; c < 10; c++) send_byte(8'h4D);
        chk("pre_cx", cursorX, 10);
        chk("pre_cy", cursorY, 29);
        send_byte(8'h0A);
        chk("scroll_addr0", mem[0], 8'h31);
        chk("scroll_row28", mem[28 * COLS + 5], 8'h4D);
        n = 0;
        for (int c = 0; c < COLS; c++) if (mem[29 * COLS + c] !== 8'h20) n++;
        chk("scroll_row29_blank", n, 0);
        compare_mem("mem_after_scroll");

        // Reset during scroll index 100
        charValid = 1'b1; charData = 8'h0A;
        @(negedge clock);
        charValid = 1'b0;
        n = 0; w = 0;
        while (w < 100 && n < 1000) begin
            @(negedge clock);
            n++;
            if (shouldWriteText) w++;
        end
        chk("abort_reach", w, 100);
        reset = 1'b0;
        @(negedge clock);
        chk("abort_wr", shouldWriteText, 1'b0);
        chk("abort_busy", isBusy, 1'b0);
        chk("abort_cx", cursorX, 0);
        chk("abort_cy", cursorY, 0);
        reset = 1'b1;
        w = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (shouldWriteText) w++;
        end
        chk("abort_no_writes", w, 0);
        for (int a = 0; a < 100; a++) exp_mem[a] = exp_mem[a + COLS];
        compare_mem("mem_after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
